// File: rtl/ftdnn_act_feeder.sv
// -----------------------------------------------------------------------------
// ftdnn_act_feeder
//
// Upstream stage of the systolic array top. Collects a scalar activation
// stream from the loader, packs consecutive scalar pairs into one 2*ACT_LEN
// word (first scalar in the low half), buffers the packed words in a small
// FIFO and drives them into the array's activation-buffer write port whenever
// the array requests data. A tile is started by a one-cycle cfg_start pulse and
// is sized by cfg_len packed pairs.
//
// Ports:
//   clk_l          in   block clock (array low-speed domain)
//   rst_n          in   synchronous active-low reset
//   cfg_start      in   one-cycle pulse, starts a tile (ignored unless idle)
//   cfg_len        in   packed pairs in the tile, sampled with cfg_start
//   s_data         in   scalar activation
//   s_vld          in   s_data is valid
//   s_rdy          out  feeder accepts s_data this cycle
//   actbuf_wr_req  in   array can take a word this cycle
//   actbuf_wr_data out  packed pair {second, first} from the FIFO head
//   actbuf_wr_vld  out  write strobe; one word is consumed per high cycle
//   busy           out  tile in progress
//   done           out  one-cycle pulse at tile completion
// -----------------------------------------------------------------------------
module ftdnn_act_feeder #(
  parameter int ACT_LEN    = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                 clk_l,
  input  logic                 rst_n,
  input  logic                 cfg_start,
  input  logic [CNT_W-1:0]     cfg_len,
  input  logic [ACT_LEN-1:0]   s_data,
  input  logic                 s_vld,
  output logic                 s_rdy,
  input  logic                 actbuf_wr_req,
  output logic [2*ACT_LEN-1:0] actbuf_wr_data,
  output logic                 actbuf_wr_vld,
  output logic                 busy,
  output logic                 done
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCNT_W = PTR_W + 1;
  localparam int WORD_W = 2 * ACT_LEN;

  localparam logic [FCNT_W-1:0] FIFO_FULL_CNT = FCNT_W'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]          state_q;
  logic [1:0]          state_d;
  logic [CNT_W-1:0]    len_q;
  logic [CNT_W-1:0]    in_cnt;
  logic [CNT_W-1:0]    out_cnt;
  logic                half_full;
  logic [ACT_LEN-1:0]  low_q;

  logic [WORD_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    rd_ptr_nxt;
  logic [FCNT_W-1:0]   fifo_cnt;
  logic [FCNT_W-1:0]   cnt_after_pop;
  logic [WORD_W-1:0]   head_q;
  logic [WORD_W-1:0]   push_word;

  logic                in_run;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_blocked;
  logic                pop;
  logic                push;
  logic                accept;

  assign in_run     = (state_q == ST_RUN);
  assign fifo_full  = (fifo_cnt == FIFO_FULL_CNT);
  assign fifo_empty = (fifo_cnt == '0);

  // req -> vld is deliberately combinational: the array samples the strobe in
  // the same cycle it raises its request.
  assign pop = in_run & actbuf_wr_req & ~fifo_empty;

  // A full FIFO only blocks the pair-completing scalar if no word leaves in the
  // same cycle; a simultaneous pop frees the slot the push needs.
  assign fifo_blocked = fifo_full & ~pop;

  assign s_rdy  = in_run & (in_cnt < len_q) & (~half_full | ~fifo_blocked);
  assign accept = s_vld & s_rdy;
  assign push   = accept & half_full;

  assign push_word     = {s_data, low_q};
  assign rd_ptr_nxt    = pop ? (rd_ptr + PTR_W'(1)) : rd_ptr;
  assign cnt_after_pop = fifo_cnt - FCNT_W'(pop);

  assign actbuf_wr_data = head_q;
  assign actbuf_wr_vld  = pop;
  assign busy           = (state_q != ST_IDLE);
  assign done           = (state_q == ST_DONE);

  // Tile sequencing. RUN ends one cycle after the final word leaves, so the
  // done pulse always follows the last write strobe.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          state_d = (cfg_len == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (out_cnt == len_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state, pair assembly and the tile counters. Counters only advance
  // in RUN; a start pulse seen outside IDLE leaves len_q untouched.
  always_ff @(posedge clk_l) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      in_cnt    <= '0;
      out_cnt   <= '0;
      half_full <= 1'b0;
      low_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE) begin
        if (cfg_start) begin
          len_q     <= cfg_len;
          in_cnt    <= '0;
          out_cnt   <= '0;
          half_full <= 1'b0;
        end
      end else begin
        if (accept) begin
          if (half_full) begin
            half_full <= 1'b0;
            in_cnt    <= in_cnt + CNT_W'(1);
          end else begin
            low_q     <= s_data;
            half_full <= 1'b1;
          end
        end
        if (pop) begin
          out_cnt <= out_cnt + CNT_W'(1);
        end
      end
    end
  end

  // FIFO storage array; left without reset since occupancy is tracked by the
  // pointers and count.
  always_ff @(posedge clk_l) begin
    if (push) begin
      mem[wr_ptr] <= push_word;
    end
  end

  // FIFO pointers, occupancy and the registered head word. head_q is loaded
  // with whatever entry will sit at the head after this edge: the word being
  // pushed if the FIFO would otherwise be empty, else the stored entry at the
  // next read pointer. When the FIFO drains, head_q keeps the last word.
  always_ff @(posedge clk_l) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      head_q   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      rd_ptr   <= rd_ptr_nxt;
      fifo_cnt <= cnt_after_pop + FCNT_W'(push);
      if (push && (cnt_after_pop == '0)) begin
        head_q <= push_word;
      end else if (cnt_after_pop != '0) begin
        head_q <= mem[rd_ptr_nxt];
      end
    end
  end

endmodule

// File: tb/tb_ftdnn_act_feeder.sv
// -----------------------------------------------------------------------------
// tb_ftdnn_act_feeder
//
// Self-checking bench for ftdnn_act_feeder. A reference model tracks each tile
// as a count of accepted scalars, a list of packed words and a count of words
// delivered, and from those derives every cycle's expected s_rdy, write strobe,
// head word, busy and done. Directed tiles cover the basic packing order,
// backpressure into a full FIFO, full push+pop, zero-length tiles, ignored
// restarts and mid-tile reset; randomized tiles follow.
// -----------------------------------------------------------------------------
module tb_ftdnn_act_feeder;

  localparam int ACT_LEN    = 16;
  localparam int FIFO_DEPTH = 8;
  localparam int CNT_W      = 16;

  localparam int PH_IDLE = 0;
  localparam int PH_RUN  = 1;
  localparam int PH_DONE = 2;

  logic                 clk_l = 1'b0;
  logic                 rst_n;
  logic                 cfg_start;
  logic [CNT_W-1:0]     cfg_len;
  logic [ACT_LEN-1:0]   s_data;
  logic                 s_vld;
  logic                 s_rdy;
  logic                 actbuf_wr_req;
  logic [2*ACT_LEN-1:0] actbuf_wr_data;
  logic                 actbuf_wr_vld;
  logic                 busy;
  logic                 done;

  ftdnn_act_feeder #(
    .ACT_LEN    (ACT_LEN),
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk_l          (clk_l),
    .rst_n          (rst_n),
    .cfg_start      (cfg_start),
    .cfg_len        (cfg_len),
    .s_data         (s_data),
    .s_vld          (s_vld),
    .s_rdy          (s_rdy),
    .actbuf_wr_req  (actbuf_wr_req),
    .actbuf_wr_data (actbuf_wr_data),
    .actbuf_wr_vld  (actbuf_wr_vld),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk_l = ~clk_l;

  int check_cnt = 0;
  int err_cnt   = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_cnt++;
    if (observed !== expected) begin
      err_cnt++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)",
               tag, observed, expected, $time);
    end
  endtask

  // Reference model state
  bit                 armed = 1'b0;
  int                 m_phase = PH_IDLE;
  int                 m_len = 0;
  int                 m_acc = 0;
  int                 m_pop = 0;
  int                 m_pop_before;
  logic [ACT_LEN-1:0] m_low = '0;
  logic [31:0]        m_last = '0;
  logic [31:0]        words_q[$];
  int                 done_seen = 0;

  int                 occ;
  bit                 e_vld;
  bit                 e_rdy;
  bit                 e_half;
  logic [31:0]        e_data;

  // Check outputs mid-cycle, then advance the model by the handshakes that the
  // coming rising edge will commit.
  always @(negedge clk_l) begin
    if (armed) begin
      occ    = words_q.size() - m_pop;
      e_half = (m_acc % 2) == 1;
      e_vld  = (m_phase == PH_RUN) && (actbuf_wr_req === 1'b1) && (occ > 0);
      e_rdy  = (m_phase == PH_RUN) && (m_acc < 2 * m_len) &&
               (!e_half || (occ < FIFO_DEPTH) || e_vld);
      e_data = (occ > 0) ? words_q[m_pop] : m_last;
      checkOutput("s_rdy",   32'(s_rdy),         32'(e_rdy));
      checkOutput("wr_vld",  32'(actbuf_wr_vld), 32'(e_vld));
      checkOutput("wr_data", actbuf_wr_data,     e_data);
      checkOutput("busy",    32'(busy),          32'(m_phase != PH_IDLE));
      checkOutput("done",    32'(done),          32'(m_phase == PH_DONE));
      if (done === 1'b1) done_seen++;
    end
    if (rst_n !== 1'b1) begin
      armed   = 1'b1;
      m_phase = PH_IDLE;
      m_len   = 0;
      m_acc   = 0;
      m_pop   = 0;
      m_low   = '0;
      m_last  = '0;
      words_q.delete();
    end else if (armed) begin
      m_pop_before = m_pop;
      if (s_vld && e_rdy) begin
        if (e_half) words_q.push_back({s_data, m_low});
        else m_low = s_data;
        m_acc++;
      end
      if (e_vld) begin
        m_last = words_q[m_pop];
        m_pop++;
      end
      case (m_phase)
        PH_IDLE: begin
          if (cfg_start) begin
            if (cfg_len == '0) begin
              m_phase = PH_DONE;
            end else begin
              m_phase = PH_RUN;
              m_len   = int'(cfg_len);
              m_acc   = 0;
              m_pop   = 0;
              words_q.delete();
            end
          end
        end
        PH_RUN:  if (m_pop_before == m_len) m_phase = PH_DONE;
        default: m_phase = PH_IDLE;
      endcase
    end
  end

  // Scalar source
  int                 accepted;
  bit                 seq_mode;
  logic [ACT_LEN-1:0] cur_scalar;
  logic [ACT_LEN-1:0] preload_q[$];

  task automatic setSource(input bit seq, input logic [ACT_LEN-1:0] first);
    seq_mode   = seq;
    cur_scalar = first;
    accepted   = 0;
    preload_q.delete();
  endtask

  task automatic nextScalar();
    if (preload_q.size() > 0) cur_scalar = preload_q.pop_front();
    else if (seq_mode) cur_scalar = cur_scalar + 1'b1;
    else cur_scalar = ACT_LEN'($urandom);
  endtask

  // One clock cycle of stimulus, entered and left just after a rising edge.
  task automatic driveCycle(input bit start, input int len, input int vld_pct,
                            input int req_pct);
    bit fire;
    cfg_start     = start;
    cfg_len       = CNT_W'(len);
    s_vld         = ($urandom_range(99) < vld_pct);
    actbuf_wr_req = ($urandom_range(99) < req_pct);
    s_data        = cur_scalar;
    @(negedge clk_l);
    fire = (s_vld === 1'b1) && (s_rdy === 1'b1);
    @(posedge clk_l);
    #1;
    if (fire) begin
      accepted++;
      nextScalar();
    end
  endtask

  task automatic applyStimulus(input bit start, input int len, input int vld_pct,
                               input int req_pct, input int ncycles);
    for (int i = 0; i < ncycles; i++) begin
      driveCycle(start && (i == 0), len, vld_pct, req_pct);
    end
  endtask

  task automatic runToIdle(input int vld_pct, input int req_pct, input int max_cycles);
    int n;
    n = 0;
    while ((busy !== 1'b0) && (n < max_cycles)) begin
      driveCycle(1'b0, 0, vld_pct, req_pct);
      n++;
    end
    if (busy !== 1'b0) checkOutput("tile_timeout", 32'(busy), 32'd0);
  endtask

  task automatic doReset(input int ncycles);
    rst_n = 1'b0;
    applyStimulus(1'b0, 0, 0, 0, ncycles);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  int done_before;
  int rlen;

  initial begin
    rst_n         = 1'b0;
    cfg_start     = 1'b0;
    cfg_len       = '0;
    s_data        = '0;
    s_vld         = 1'b0;
    actbuf_wr_req = 1'b0;
    setSource(1'b1, 16'h0001);
    @(posedge clk_l);
    #1;
    doReset(3);
    applyStimulus(1'b0, 0, 0, 0, 2);

    $display("[TB] basic tile, cfg_len=3");
    setSource(1'b1, 16'h0001);
    done_before = done_seen;
    applyStimulus(1'b1, 3, 100, 100, 1);
    runToIdle(100, 100, 50);
    checkOutput("tile1_accepted", 32'(accepted), 32'd6);
    checkOutput("tile1_done_pulses", 32'(done_seen - done_before), 32'd1);
    checkOutput("tile1_last_word", actbuf_wr_data, 32'h0006_0005);
    applyStimulus(1'b0, 0, 100, 100, 3);

    $display("[TB] backpressure into a full FIFO, cfg_len=10");
    setSource(1'b1, 16'h0100);
    applyStimulus(1'b1, 10, 100, 0, 25);
    checkOutput("bp_buffered", 32'(accepted), 32'(2 * FIFO_DEPTH + 1));
    runToIdle(100, 100, 80);
    checkOutput("bp_accepted", 32'(accepted), 32'd20);

    $display("[TB] zero-length tile");
    done_before = done_seen;
    applyStimulus(1'b1, 0, 100, 100, 1);
    runToIdle(100, 100, 5);
    checkOutput("len0_done_pulses", 32'(done_seen - done_before), 32'd1);

    $display("[TB] start during RUN is ignored");
    setSource(1'b0, 16'h1234);
    applyStimulus(1'b1, 4, 100, 0, 3);
    applyStimulus(1'b1, 9, 100, 0, 2);
    runToIdle(100, 100, 60);
    checkOutput("restart_ignored_accepted", 32'(accepted), 32'd8);

    $display("[TB] reset mid-tile");
    setSource(1'b1, 16'h1000);
    applyStimulus(1'b1, 6, 0, 0, 1);
    applyStimulus(1'b0, 0, 100, 0, 7);
    checkOutput("pre_reset_accepted", 32'(accepted), 32'd7);
    doReset(1);
    checkOutput("post_reset_busy", 32'(busy), 32'd0);
    checkOutput("post_reset_data", actbuf_wr_data, 32'd0);
    setSource(1'b1, 16'hAAAA);
    preload_q.push_back(16'hBBBB);
    applyStimulus(1'b1, 1, 100, 100, 1);
    runToIdle(100, 100, 20);
    checkOutput("post_reset_accepted", 32'(accepted), 32'd2);
    checkOutput("post_reset_word", actbuf_wr_data, 32'hBBBB_AAAA);

    $display("[TB] randomized tiles");
    for (int t = 0; t < 8; t++) begin
      rlen = int'($urandom_range(1, 20));
      setSource(1'b0, 16'($urandom));
      applyStimulus(1'b1, rlen, 70, 60, 1);
      runToIdle(70, 60, 600);
      checkOutput("rand_accepted", 32'(accepted), 32'(2 * rlen));
      applyStimulus(1'b0, int'($urandom_range(0, 65535)), 50, 50, 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
    $finish;
  end

endmodule
